// File: rtl/turing_pkg.sv
// rtl/turing_pkg.sv - shared types and constants for the program sequencer
package turing_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    // Opcode field inst[7:6]
    localparam logic [1:0] OP_IMM  = 2'b00;
    localparam logic [1:0] OP_CALC = 2'b01;
    localparam logic [1:0] OP_COPY = 2'b10;
    localparam logic [1:0] OP_COND = 2'b11;

    // Condition codes inst[2:0], evaluated on reg3 as a signed byte
    localparam logic [2:0] CC_NEVER  = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_LT     = 3'b010;
    localparam logic [2:0] CC_LE     = 3'b011;
    localparam logic [2:0] CC_ALWAYS = 3'b100;
    localparam logic [2:0] CC_NE     = 3'b101;
    localparam logic [2:0] CC_GE     = 3'b110;
    localparam logic [2:0] CC_GT     = 3'b111;

    // Extract the opcode field from an instruction byte
    function automatic logic [1:0] opcode_of(input logic [7:0] instr);
        return instr[7:6];
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch-condition evaluation on a signed byte
module cond_eval
    import turing_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [7:0] value,
    output logic       taken
);

    logic w_zero;
    logic w_neg;

    assign w_zero = (value == 8'h00);
    assign w_neg  = value[7];

    // Decode the condition code against the sign/zero flags of value
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_NEVER:  taken = 1'b0;
            CC_EQ:     taken = w_zero;
            CC_LT:     taken = w_neg;
            CC_LE:     taken = w_neg | w_zero;
            CC_ALWAYS: taken = 1'b1;
            CC_NE:     taken = ~w_zero;
            CC_GE:     taken = ~w_neg;
            CC_GT:     taken = ~w_neg & ~w_zero;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/execute program sequencer with conditional branch
module program_sequencer
    import turing_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] inst,
    output logic       inst_valid,
    input  logic [7:0] reg0,
    input  logic [7:0] reg3,
    output logic [7:0] pc,
    output logic       busy
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_pc;
    logic [7:0] r_inst;
    logic [7:0] w_pc_next;
    logic       w_taken;
    logic       w_branch;

    // Condition is always decoded from the held instruction; it only matters in EXEC
    cond_eval u_cond_eval (
        .cond  (r_inst[2:0]),
        .value (reg3),
        .taken (w_taken)
    );

    assign w_branch  = (opcode_of(r_inst) == OP_COND) && w_taken;
    assign w_pc_next = w_branch ? reg0 : (r_pc + 8'd1);

    assign mem_addr = r_pc;
    assign pc       = r_pc;
    assign inst     = r_inst;

    // State register; reset overrides every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs; acks outside FETCH never advance the FSM
    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        inst_valid   = 1'b0;
        busy         = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                inst_valid   = 1'b1;
                w_state_next = stop ? ST_IDLE : ST_FETCH;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction capture on the ack cycle and pc update at the end of EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= 8'h00;
            r_inst <= 8'h00;
        end else begin
            if ((r_state == ST_FETCH) && mem_ack) begin
                r_inst <= mem_rdata;
            end
            if (r_state == ST_EXEC) begin
                r_pc <= w_pc_next;
            end
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] inst;
    logic       inst_valid;
    logic [7:0] reg0;
    logic [7:0] reg3;
    logic [7:0] pc;
    logic       busy;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .reg0       (reg0),
        .reg3       (reg3),
        .pc         (pc),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] prog [256];
    int         ack_delay   = 0;
    bit         random_mode = 0;
    bit         spurious_en = 0;

    int         pulses;
    int         req_cycles;
    bit         addr_stable;
    logic [7:0] q_inst [$];
    logic [7:0] q_pc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Condition semantics straight from the signed comparisons
    function automatic bit cond_true(input logic [2:0] c, input logic [7:0] v);
        int s;
        s = $signed(v);
        case (c)
            3'd0: return 1'b0;
            3'd1: return s == 0;
            3'd2: return s < 0;
            3'd3: return s <= 0;
            3'd4: return 1'b1;
            3'd5: return s != 0;
            3'd6: return s >= 0;
            default: return s > 0;
        endcase
    endfunction

    // Reference model: running/has-instruction flags, pc and instruction byte
    bit         m_ok = 0;
    bit         m_run;
    bit         m_have;
    logic [7:0] m_pc;
    logic [7:0] m_inst;

    // Compare on the falling edge, then advance the model with the inputs the DUT will sample next
    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("mem_req",    mem_req,    m_run && !m_have);
                chk("mem_addr",   mem_addr,   m_pc);
                chk("inst_valid", inst_valid, m_run && m_have);
                chk("inst",       inst,       m_inst);
                chk("pc",         pc,         m_pc);
                chk("busy",       busy,       m_run);
            end
            if (rst) begin
                m_ok   = 1;
                m_run  = 0;
                m_have = 0;
                m_pc   = 8'h00;
                m_inst = 8'h00;
            end else if (m_ok) begin
                if (!m_run) begin
                    if (start) begin
                        m_run  = 1;
                        m_have = 0;
                    end
                end else if (!m_have) begin
                    if (mem_ack) begin
                        m_inst = mem_rdata;
                        m_have = 1;
                    end
                end else begin
                    if (m_inst[7:6] == 2'b11 && cond_true(m_inst[2:0], reg3))
                        m_pc = reg0;
                    else
                        m_pc = m_pc + 8'd1;
                    m_have = 0;
                    if (stop) m_run = 0;
                end
            end
        end
    end

    // Memory responder: acks after ack_delay request cycles, optionally sprays stray acks
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = prog[mem_addr];
                    wait_cnt  = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'($urandom);
                    wait_cnt++;
                end
            end else begin
                wait_cnt  = 0;
                mem_ack   = spurious_en && ($urandom_range(0, 2) == 0);
                mem_rdata = 8'($urandom);
                if (random_mode) ack_delay = $urandom_range(0, 3);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start from IDLE and execute n instructions, raising stop mid-FETCH of the last one
    task automatic run_n(input int n);
        logic [7:0] prev_addr;
        bit         prev_req;
        bit         done;
        pulses      = 0;
        req_cycles  = 0;
        addr_stable = 1;
        prev_req    = 0;
        prev_addr   = 8'h00;
        done        = 0;
        q_inst.delete();
        q_pc.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (mem_req) begin
                req_cycles++;
                if (prev_req && mem_addr != prev_addr) addr_stable = 0;
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
            if (inst_valid) begin
                pulses++;
                q_inst.push_back(inst);
                q_pc.push_back(pc);
            end
            if (pulses == n - 1 && !inst_valid && mem_req) stop = 1'b1;
            if (!busy) done = 1;
            else tick();
        end
        stop = 1'b0;
        chk("run_timeout", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cnt;
        bit seen;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        reg0  = 8'h00;
        reg3  = 8'h00;
        for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pc", pc, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 8'h00);

        // Three sequential instructions with immediate acks
        prog[0] = 8'h00; prog[1] = 8'h41; prog[2] = 8'h82;
        run_n(3);
        chk("seq_pulses", pulses, 3);
        if (pulses == 3) begin
            chk("seq_i0", q_inst[0], 8'h00);
            chk("seq_i1", q_inst[1], 8'h41);
            chk("seq_i2", q_inst[2], 8'h82);
            chk("seq_pc1", q_pc[1], 8'h01);
            chk("seq_pc2", q_pc[2], 8'h02);
        end
        chk("seq_pc_end", pc, 8'h03);
        chk("seq_busy", busy, 0);

        // Wrap from 0xFF to 0x00
        prog[3] = 8'hC4; prog[8'hFF] = 8'h44; reg0 = 8'hFF;
        run_n(2);
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_addr", mem_addr, 8'h00);

        // Conditional branches
        prog[0] = 8'hC1; reg3 = 8'h00; reg0 = 8'h20;
        run_n(1);
        chk("c1_taken", pc, 8'h20);
        prog[8'h20] = 8'hC1; reg3 = 8'h80;
        run_n(1);
        chk("c1_not", pc, 8'h21);
        prog[8'h21] = 8'hC2;
        run_n(1);
        chk("c2_taken", pc, 8'h20);
        prog[8'h20] = 8'hC7; reg3 = 8'h7F; reg0 = 8'h50;
        run_n(1);
        chk("c7_taken", pc, 8'h50);

        // Self-loop refetches the same address
        prog[8'h50] = 8'hC4;
        run_n(3);
        chk("loop_pulses", pulses, 3);
        chk("loop_pc", pc, 8'h50);

        // Slow memory: request held six cycles, one execution
        ack_delay = 5;
        prog[8'h50] = 8'h02;
        run_n(1);
        ack_delay = 0;
        chk("slow_req", req_cycles, 6);
        chk("slow_pulses", pulses, 1);
        chk("slow_stable", addr_stable, 1);
        chk("slow_pc", pc, 8'h51);

        // start and stop together in IDLE still fetches
        prog[8'h51] = 8'h80;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0;
        chk("ss_busy", busy, 1);
        chk("ss_req", mem_req, 1);
        cnt = 0;
        while (busy && cnt < 50) begin tick(); cnt++; end
        stop = 1'b0;
        chk("ss_idle", busy, 0);
        chk("ss_pc", pc, 8'h52);

        // Reset during EXEC of a taken branch
        prog[8'h52] = 8'hC4; reg0 = 8'h99;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!inst_valid && cnt < 50) begin tick(); cnt++; end
        chk("rx_exec", inst_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_pc", pc, 8'h00);
        chk("rx_busy", busy, 0);
        chk("rx_inst", inst, 8'h00);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (inst_valid) seen = 1;
            tick();
        end
        chk("rx_quiet", seen, 0);

        // Randomized traffic checked by the model
        random_mode = 1;
        spurious_en = 1;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 5) == 0);
            reg0  = 8'($urandom);
            case ($urandom_range(0, 5))
                0: reg3 = 8'h00;
                1: reg3 = 8'h80;
                2: reg3 = 8'hFF;
                3: reg3 = 8'h7F;
                4: reg3 = 8'h01;
                default: reg3 = 8'($urandom);
            endcase
            if (!busy) prog[$urandom_range(0, 255)] = 8'($urandom);
            tick();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
